loop_status_monitor: RTL and testbench

LOOP_STATUS_MONITOR -- requirements
Module: loop_status_monitor

---
 rtl/loop_mon_pkg.sv | 27 ++
 rtl/sat_counter.sv | 35 +++
 rtl/loop_status_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_loop_status_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_mon_pkg.sv
// Shared types and helpers for the loop status monitor.
// The status encoding and the saturating increment live here.
package loop_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_DONE_WAIT = 2'd2
    } status_e;

    // Widest counter the helper supports; callers zero-extend into it.
    localparam int unsigned SAT_MAX_W = 64;

    // Returns value+1 unless the low 'width' bits are already all ones.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] mask;
        mask = (width >= SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        if ((value & mask) == mask) begin
            return value;
        end
        return value + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and hold; CNT_W must not exceed 64.
// Clear takes priority over increment, hold freezes everything.
module sat_counter
    import loop_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = CNT_W'(sat_inc(64'(r_count), CNT_W));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!hold) begin
            if (clr) begin
                r_count <= '0;
            end else if (inc) begin
                r_count <= w_count_inc;
            end
        end
    end

    assign count = r_count;

endmodule

// File: rtl/loop_status_monitor.sv
// Observes an HLS block handshake and its loop FSM: transaction/iteration counts,
// latency, open iterations and overflow. Optional stall counter: LOOP_MON_STALL_CNT_EN.
module loop_status_monitor
    import loop_mon_pkg::*;
#(
    parameter int STATE_W      = 8,
    parameter int CNT_W        = 32,
    parameter int MAX_INFLIGHT = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              finish,
    input  logic                              ap_start,
    input  logic                              ap_ready,
    input  logic                              ap_done,
    input  logic                              ap_continue,
    input  logic [STATE_W-1:0]                cur_state,
    input  logic [STATE_W-1:0]                iter_start_state,
    input  logic [STATE_W-1:0]                iter_end_state,
    input  logic                              iter_start_block,
    input  logic                              iter_end_block,
    input  logic                              iter_start_enable,
    input  logic                              iter_end_enable,
    output logic [1:0]                        status,
    output logic [CNT_W-1:0]                  trans_count,
    output logic [CNT_W-1:0]                  last_latency,
    output logic [CNT_W-1:0]                  iter_count,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  stall_count,
    output logic                              frozen
);

    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    status_e          r_state;
    status_e          w_state_next;
    logic             r_frozen;
    logic             w_txn_start;
    logic             w_run_exit;
    logic             w_done_in_run;
    logic             w_run;
    logic             w_start_ev;
    logic             w_end_ev;
    logic             w_start_err;
    logic             w_end_err;
    logic [CNT_W-1:0] w_latency;
    logic [CNT_W-1:0] r_last_latency;
    logic [INF_W-1:0] r_inflight;
    logic [INF_W-1:0] w_inflight_next;
    logic             r_overflow;
    logic             w_unused_ready;

    // ap_ready carries no information the counters need.
    assign w_unused_ready = ap_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (!r_frozen) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_txn_start   = 1'b0;
        w_run_exit    = 1'b0;
        w_done_in_run = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_next = ST_RUN;
                    w_txn_start  = 1'b1;
                end
            end
            ST_RUN: begin
                if (ap_done) begin
                    w_done_in_run = 1'b1;
                    if (!ap_continue) begin
                        w_state_next = ST_DONE_WAIT;
                    end else if (ap_start) begin
                        w_state_next = ST_RUN;
                        w_txn_start  = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_run_exit   = 1'b1;
                    end
                end
            end
            ST_DONE_WAIT: begin
                if (ap_continue) begin
                    if (ap_start) begin
                        w_state_next = ST_RUN;
                        w_txn_start  = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_start_ev = (cur_state == iter_start_state) & iter_start_enable
                      & ~iter_start_block & w_run;
    assign w_end_ev   = (cur_state == iter_end_state) & iter_end_enable
                      & ~iter_end_block & w_run;

    // A new transaction (from any state) restarts the latency count.
    sat_counter #(.CNT_W(CNT_W)) u_latency (
        .clock (clock),
        .reset (reset),
        .inc   (w_run),
        .clr   (w_txn_start),
        .hold  (r_frozen),
        .count (w_latency)
    );

    sat_counter #(.CNT_W(CNT_W)) u_trans (
        .clock (clock),
        .reset (reset),
        .inc   (w_done_in_run),
        .clr   (1'b0),
        .hold  (r_frozen),
        .count (trans_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_iter (
        .clock (clock),
        .reset (reset),
        .inc   (w_end_ev),
        .clr   (1'b0),
        .hold  (r_frozen),
        .count (iter_count)
    );

`ifdef LOOP_MON_STALL_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clock (clock),
        .reset (reset),
        .inc   (w_run & (cur_state == iter_start_state) & iter_start_block),
        .clr   (1'b0),
        .hold  (r_frozen),
        .count (stall_count)
    );
`else
    assign stall_count = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_latency <= '0;
        end else if (!r_frozen && w_done_in_run) begin
            r_last_latency <= CNT_W'(sat_inc(64'(w_latency), CNT_W));
        end
    end

    // Simultaneous start and end cancel; errors leave the count pinned at its bound.
    assign w_start_err = w_start_ev & ~w_end_ev & (r_inflight == INF_MAX);
    assign w_end_err   = w_end_ev & ~w_start_ev & (r_inflight == '0);

    always_comb begin
        w_inflight_next = r_inflight;
        if (w_run_exit) begin
            w_inflight_next = '0;
        end else if (w_start_ev && !w_end_ev && !w_start_err) begin
            w_inflight_next = r_inflight + INF_W'(1);
        end else if (w_end_ev && !w_start_ev && !w_end_err) begin
            w_inflight_next = r_inflight - INF_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_overflow <= 1'b0;
        end else if (!r_frozen) begin
            r_inflight <= w_inflight_next;
            r_overflow <= r_overflow | w_start_err | w_end_err;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frozen <= 1'b0;
        end else if (finish) begin
            r_frozen <= 1'b1;
        end
    end

    assign status       = r_state;
    assign last_latency = r_last_latency;
    assign inflight     = r_inflight;
    assign overflow     = r_overflow;
    assign frozen       = r_frozen;

endmodule

// File: tb/tb_loop_status_monitor.sv
// Directed bench for loop_status_monitor (MAX_INFLIGHT=2, loop states both 5).
// Stall expectation follows LOOP_MON_STALL_CNT_EN.
module tb_loop_status_monitor;

    localparam int STATE_W = 8;
    localparam int CNT_W   = 32;
    localparam int MAXI    = 2;
`ifdef LOOP_MON_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd4;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               finish;
    logic               ap_start, ap_ready, ap_done, ap_continue;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state;
    logic               iter_start_block, iter_end_block;
    logic               iter_start_enable, iter_end_enable;
    logic [1:0]         status;
    logic [CNT_W-1:0]   trans_count, last_latency, iter_count, stall_count;
    logic [1:0]         inflight;
    logic               overflow, frozen;

    int n_checks = 0;
    int n_pass   = 0;

    loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W), .MAX_INFLIGHT(MAXI)) dut (
        .clock             (clock),
        .reset             (reset),
        .finish            (finish),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .status            (status),
        .trans_count       (trans_count),
        .last_latency      (last_latency),
        .iter_count        (iter_count),
        .inflight          (inflight),
        .overflow          (overflow),
        .stall_count       (stall_count),
        .frozen            (frozen)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (status !== 2'd0) $display("FAIL reset_status got=%0d exp=0", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd0) $display("FAIL reset_trans got=%0d exp=0", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd0) $display("FAIL reset_lat got=%0d exp=0", last_latency); else n_pass++;
        n_checks++; if (iter_count !== 32'd0) $display("FAIL reset_iter got=%0d exp=0", iter_count); else n_pass++;
        n_checks++; if (inflight !== 2'd0) $display("FAIL reset_inflight got=%0d exp=0", inflight); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%0d exp=0", overflow); else n_pass++;
        n_checks++; if (stall_count !== 32'd0) $display("FAIL reset_stall got=%0d exp=0", stall_count); else n_pass++;
        n_checks++; if (frozen !== 1'b0) $display("FAIL reset_frozen got=%0d exp=0", frozen); else n_pass++;
        reset = 1'b0;
        $display("txn reset: status=%0d trans=%0d", status, trans_count);
    endtask

    // Start pulse, five idle RUN cycles, done on the sixth RUN cycle -> latency 6.
    task automatic test_single_txn();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        n_checks++; if (status !== 2'd1) $display("FAIL single_run got=%0d exp=1", status); else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        ap_done = 1'b1; ap_continue = 1'b1;
        tick();
        ap_done = 1'b0; ap_continue = 1'b0;
        n_checks++; if (status !== 2'd0) $display("FAIL single_idle got=%0d exp=0", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd1) $display("FAIL single_trans got=%0d exp=1", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd6) $display("FAIL single_lat got=%0d exp=6", last_latency); else n_pass++;
        $display("txn single: trans=%0d last_latency=%0d", trans_count, last_latency);
    endtask

    task automatic test_done_wait();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        ap_done = 1'b1; ap_continue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (status !== 2'd2) $display("FAIL done_wait_status[%0d] got=%0d exp=2", i, status); else n_pass++;
        end
        ap_done = 1'b0; ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        n_checks++; if (status !== 2'd0) $display("FAIL done_wait_release got=%0d exp=0", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd2) $display("FAIL done_wait_trans got=%0d exp=2", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd1) $display("FAIL done_wait_lat got=%0d exp=1", last_latency); else n_pass++;
        $display("txn done_wait: trans=%0d last_latency=%0d", trans_count, last_latency);
    endtask

    // Done+continue+start restarts in RUN with a fresh latency count.
    task automatic test_back_to_back();
        ap_start = 1'b1;
        tick();
        ap_done = 1'b1; ap_continue = 1'b1;
        tick();
        ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
        n_checks++; if (status !== 2'd1) $display("FAIL b2b_status got=%0d exp=1", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd3) $display("FAIL b2b_trans got=%0d exp=3", trans_count); else n_pass++;
        tick();
        tick();
        ap_done = 1'b1; ap_continue = 1'b1;
        tick();
        ap_done = 1'b0; ap_continue = 1'b0;
        n_checks++; if (status !== 2'd0) $display("FAIL b2b_idle got=%0d exp=0", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd4) $display("FAIL b2b_trans2 got=%0d exp=4", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd3) $display("FAIL b2b_lat got=%0d exp=3", last_latency); else n_pass++;
        $display("txn back_to_back: trans=%0d last_latency=%0d", trans_count, last_latency);
    endtask

    // II=1: ten starts, ends trailing by one cycle; inflight settles at 1 then drains.
    task automatic test_ii1_loop();
        logic [1:0] exp_inf;
        cur_state = 8'd5; iter_start_state = 8'd5; iter_end_state = 8'd5;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            iter_start_enable = (k < 10);
            iter_end_enable   = (k >= 1);
            tick();
            exp_inf = (k < 10) ? 2'd1 : 2'd0;
            n_checks++; if (inflight !== exp_inf) $display("FAIL ii1_inflight[%0d] got=%0d exp=%0d", k, inflight, exp_inf); else n_pass++;
        end
        iter_start_enable = 1'b0; iter_end_enable = 1'b0;
        n_checks++; if (iter_count !== 32'd10) $display("FAIL ii1_iter got=%0d exp=10", iter_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ii1_overflow got=%0d exp=0", overflow); else n_pass++;
        $display("txn ii1_loop: iter=%0d inflight=%0d overflow=%0d", iter_count, inflight, overflow);
    endtask

    task automatic test_inflight_limit();
        iter_start_enable = 1'b1;
        tick();
        n_checks++; if (inflight !== 2'd1) $display("FAIL limit_inf1 got=%0d exp=1", inflight); else n_pass++;
        tick();
        n_checks++; if (inflight !== 2'd2) $display("FAIL limit_inf2 got=%0d exp=2", inflight); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL limit_ovf_early got=%0d exp=0", overflow); else n_pass++;
        tick();
        iter_start_enable = 1'b0;
        n_checks++; if (inflight !== 2'd2) $display("FAIL limit_inf_hold got=%0d exp=2", inflight); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL limit_ovf got=%0d exp=1", overflow); else n_pass++;
        $display("txn inflight_limit: inflight=%0d overflow=%0d", inflight, overflow);
    endtask

    // RUN->IDLE clears inflight; RUN lasted 11+3+1 cycles.
    task automatic test_run_exit_clear();
        ap_done = 1'b1; ap_continue = 1'b1;
        tick();
        ap_done = 1'b0; ap_continue = 1'b0;
        n_checks++; if (status !== 2'd0) $display("FAIL exit_status got=%0d exp=0", status); else n_pass++;
        n_checks++; if (inflight !== 2'd0) $display("FAIL exit_inflight got=%0d exp=0", inflight); else n_pass++;
        n_checks++; if (trans_count !== 32'd5) $display("FAIL exit_trans got=%0d exp=5", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd15) $display("FAIL exit_lat got=%0d exp=15", last_latency); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL exit_ovf_sticky got=%0d exp=1", overflow); else n_pass++;
        $display("txn run_exit: trans=%0d last_latency=%0d", trans_count, last_latency);
    endtask

    // Reset between edges clears at once; next transaction starts clean.
    task automatic test_async_reset_mid();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (status !== 2'd0) $display("FAIL areset_status got=%0d exp=0", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd0) $display("FAIL areset_trans got=%0d exp=0", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd0) $display("FAIL areset_lat got=%0d exp=0", last_latency); else n_pass++;
        n_checks++; if (iter_count !== 32'd0) $display("FAIL areset_iter got=%0d exp=0", iter_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL areset_ovf got=%0d exp=0", overflow); else n_pass++;
        reset = 1'b0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        n_checks++; if (status !== 2'd1) $display("FAIL areset_restart got=%0d exp=1", status); else n_pass++;
        ap_done = 1'b1; ap_continue = 1'b1;
        tick();
        ap_done = 1'b0; ap_continue = 1'b0;
        n_checks++; if (trans_count !== 32'd1) $display("FAIL areset_trans2 got=%0d exp=1", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd1) $display("FAIL areset_lat2 got=%0d exp=1", last_latency); else n_pass++;
        $display("txn async_reset: trans=%0d last_latency=%0d", trans_count, last_latency);
    endtask

    task automatic test_underflow();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        iter_end_enable = 1'b1;
        tick();
        iter_end_enable = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL under_ovf got=%0d exp=1", overflow); else n_pass++;
        n_checks++; if (iter_count !== 32'd1) $display("FAIL under_iter got=%0d exp=1", iter_count); else n_pass++;
        n_checks++; if (inflight !== 2'd0) $display("FAIL under_inflight got=%0d exp=0", inflight); else n_pass++;
        tick();
        n_checks++; if (overflow !== 1'b1) $display("FAIL under_sticky got=%0d exp=1", overflow); else n_pass++;
        $display("txn underflow: iter=%0d overflow=%0d", iter_count, overflow);
    endtask

    task automatic test_stall();
        iter_start_enable = 1'b1; iter_start_block = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        iter_start_enable = 1'b0; iter_start_block = 1'b0;
        n_checks++; if (stall_count !== EXP_STALL) $display("FAIL stall_count got=%0d exp=%0d", stall_count, EXP_STALL); else n_pass++;
        n_checks++; if (inflight !== 2'd0) $display("FAIL stall_inflight got=%0d exp=0", inflight); else n_pass++;
        $display("txn stall: stall_count=%0d", stall_count);
    endtask

    // Freeze in RUN, then throw events at it; nothing may move until reset.
    task automatic test_freeze();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n_checks++; if (frozen !== 1'b1) $display("FAIL freeze_set got=%0d exp=1", frozen); else n_pass++;
        iter_start_enable = 1'b1; iter_start_block = 1'b1;
        tick();
        iter_start_block = 1'b0;
        tick();
        iter_start_enable = 1'b0;
        ap_done = 1'b1; ap_continue = 1'b1; iter_end_enable = 1'b1;
        tick();
        ap_done = 1'b0; ap_continue = 1'b0; iter_end_enable = 1'b0;
        n_checks++; if (status !== 2'd1) $display("FAIL freeze_status got=%0d exp=1", status); else n_pass++;
        n_checks++; if (trans_count !== 32'd1) $display("FAIL freeze_trans got=%0d exp=1", trans_count); else n_pass++;
        n_checks++; if (last_latency !== 32'd1) $display("FAIL freeze_lat got=%0d exp=1", last_latency); else n_pass++;
        n_checks++; if (iter_count !== 32'd1) $display("FAIL freeze_iter got=%0d exp=1", iter_count); else n_pass++;
        n_checks++; if (inflight !== 2'd0) $display("FAIL freeze_inflight got=%0d exp=0", inflight); else n_pass++;
        n_checks++; if (stall_count !== EXP_STALL) $display("FAIL freeze_stall got=%0d exp=%0d", stall_count, EXP_STALL); else n_pass++;
        n_checks++; if (frozen !== 1'b1) $display("FAIL freeze_hold got=%0d exp=1", frozen); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (frozen !== 1'b0) $display("FAIL freeze_rst_frozen got=%0d exp=0", frozen); else n_pass++;
        n_checks++; if (status !== 2'd0) $display("FAIL freeze_rst_status got=%0d exp=0", status); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL freeze_rst_ovf got=%0d exp=0", overflow); else n_pass++;
        n_checks++; if (iter_count !== 32'd0) $display("FAIL freeze_rst_iter got=%0d exp=0", iter_count); else n_pass++;
        n_checks++; if (stall_count !== 32'd0) $display("FAIL freeze_rst_stall got=%0d exp=0", stall_count); else n_pass++;
        reset = 1'b0;
        $display("txn freeze: frozen=%0d status=%0d", frozen, status);
    endtask

    initial begin
        reset = 1'b1; finish = 1'b0;
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
        cur_state = '0; iter_start_state = '0; iter_end_state = '0;
        iter_start_block = 1'b0; iter_end_block = 1'b0;
        iter_start_enable = 1'b0; iter_end_enable = 1'b0;
        test_reset();
        test_single_txn();
        test_done_wait();
        test_back_to_back();
        test_ii1_loop();
        test_inflight_limit();
        test_run_exit_clear();
        test_async_reset_mid();
        test_underflow();
        test_stall();
        test_freeze();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
